fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front end for the single-issue MIPS core. It is the producer side of the main decoder interface.
- Holds the PC and issues word reads to instruction memory.
- Latches the returned word into an instruction register and presents opcode and fields to the decoder.
- Consumes the decoder's branch control, together with the ALU zero flag, to select the next PC.
- Sits between the instruction memory port and the decoder/register file.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
IMEM_AW, 32, instruction memory address width in bits.

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  read request to instruction memory.
imem_addr  output  IMEM_AW  word-aligned byte address of the request.
imem_ready  input  1  read data valid this cycle; may assert in the same cycle as imem_req.
imem_rdata  input  32  instruction word; sampled only when imem_req && imem_ready.
stall  input  1  downstream not ready; hold the current instruction.
branch  input  1  decoder branch control for the presented instruction.
zero  input  1  ALU zero flag for the presented instruction.
instr_valid  output  1  instruction register holds a live instruction.
opcode  output  6  IR[31:26], drives the decoder.
rs  output  5  IR[25:21].
rt  output  5  IR[20:16].
rd  output  5  IR[15:11].
funct  output  6  IR[5:0].
imm  output  16  IR[15:0].
pc  output  IMEM_AW  address of the presented instruction.
pc_plus4  output  IMEM_AW  pc + 4.

Behaviour:
- Reset (asynchronous, immediate):
  - pc = RESET_PC.
  - IR = 0, so opcode = 6'b000000.
  - instr_valid = 0, imem_req = 0.
  - State = FETCH.
- FSM states: FETCH, HOLD.
- FETCH:
  - imem_req = 1 and imem_addr = pc, combinationally.
  - If imem_ready: IR <= imem_rdata, instr_valid <= 1, next state HOLD.
  - Otherwise stay in FETCH with imem_req held and the address stable.
- HOLD:
  - imem_req = 0; IR and pc are frozen.
  - If stall: remain in HOLD; branch and zero are ignored.
  - If !stall, commit the instruction this cycle:
    - Taken when branch && zero: pc <= pc_plus4 + ({{14{imm[15]}}, imm, 2'b00}).
    - Otherwise: pc <= pc_plus4.
    - instr_valid <= 0, next state FETCH.
- Latency: minimum 2 cycles per instruction, with a zero-wait memory (FETCH+ready, then HOLD+!stall). Each imem wait cycle adds 1.
- Arithmetic:
  - All PC sums are modulo 2^IMEM_AW; 32'hFFFF_FFFC + 4 wraps to 0.
  - imem_addr[1:0] is always 00.
  - Branch offset is sign-extended and shifted left by 2.
- Opcode passthrough: unrecognised opcodes are presented unchanged and fall through to pc_plus4.
- pc_plus4 is combinational from pc.
- branch and zero are sampled only in HOLD with !stall.
- Reset mid-operation:
  - An outstanding request is abandoned.
  - A late imem_ready after reset is ignored unless the block is again in FETCH, where it is treated as a fresh response.

Optional Feature:
Macro FETCH_JUMP_EN.
- Defined: opcode 6'b000010 (j) commits with pc <= {pc_plus4[31:28], IR[25:0], 2'b00}. This takes priority over the branch path.
- Undefined: j is treated as any other non-branch instruction (pc <= pc_plus4). No extra logic is generated.

Decomposition:
- Shared package core_pkg holds:
  - opcode constants OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  - the fetch state encoding FETCH / HOLD;
  - RESET_PC default.
- One sub-module, fetch_next_pc: purely combinational. It computes pc_plus4 and the branch target, and under FETCH_JUMP_EN the jump target. It selects the next PC from branch, zero and opcode.

Test Plan:
- Sequential fetch: release reset, RESET_PC = 0, zero-wait memory returning 32'h0000_0020 (add) at 0 and 4, stall = 0. Expect imem_addr 0, 4, 8 on successive FETCH cycles; opcode 000000; instr_valid high on alternate cycles.
- Taken beq: IR = 32'h1000_0003 at pc = 8, branch = 1, zero = 1. Expect next imem_addr = 8 + 4 + 12 = 24.
- Not-taken and backward branch:
  - branch = 1, zero = 0 gives next pc = 12.
  - IR = 32'h1000_FFFF at pc = 16, taken, gives next pc = 16 (self-loop).
- Stall and wait states:
  - imem_ready held low 3 cycles: imem_addr stays stable, instr_valid = 0.
  - Then stall = 1 for 2 cycles in HOLD: IR and pc are unchanged and branch/zero toggles are ignored.
- Reset mid-fetch and wrap:
  - Assert reset while in FETCH at pc = 40. Expect pc = RESET_PC, instr_valid = 0, opcode = 0 immediately, without waiting for a clock edge.
  - Separately, pc = 32'hFFFF_FFFC not-taken gives next pc = 0.
- FETCH_JUMP_EN:
  - IR = 32'h0800_0010 at pc = 32'h1000_0000 gives next pc = 32'h1000_0040 when defined, and 32'h1000_0004 when undefined.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants, fetch FSM encoding, reset PC.
package core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Fetch FSM encoding
  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch unit (purely combinational).
// Build option FETCH_JUMP_EN adds the j-instruction target path.
module fetch_next_pc
  import core_pkg::*;
#(
  parameter int IMEM_AW = 32
) (
  input  logic [IMEM_AW-1:0] pc,
  input  logic [5:0]         opcode,
  input  logic [15:0]        imm,
  input  logic [25:0]        target,
  input  logic               branch,
  input  logic               zero,
  output logic [IMEM_AW-1:0] pc_plus4,
  output logic [IMEM_AW-1:0] next_pc
);

  logic [IMEM_AW-1:0] br_target;

  assign pc_plus4  = pc + IMEM_AW'(4);
  // Word offset, sign-extended to the address width; sums wrap naturally.
  assign br_target = pc_plus4 + {{(IMEM_AW-18){imm[15]}}, imm, 2'b00};

`ifdef FETCH_JUMP_EN
  logic [IMEM_AW-1:0] j_target;
  assign j_target = {pc_plus4[IMEM_AW-1:28], target, 2'b00};

  // Jump outranks branch; everything else falls through to pc+4.
  always_comb begin
    next_pc = pc_plus4;
    if (branch && zero)   next_pc = br_target;
    if (opcode == OP_J)   next_pc = j_target;
  end
`else
  // Jump fields only matter when the jump path is built.
  logic unused_j;
  assign unused_j = ^{opcode, target};

  // Taken branch or fall through to pc+4.
  always_comb begin
    next_pc = pc_plus4;
    if (branch && zero) next_pc = br_target;
  end
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, imem request, instruction register,
// next-PC commit. Optional jump support via macro FETCH_JUMP_EN.
module fetch_unit
  import core_pkg::*;
#(
  parameter int                 IMEM_AW  = 32,
  parameter logic [IMEM_AW-1:0] RESET_PC = RESET_PC_DEFAULT[IMEM_AW-1:0]
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ready,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               branch,
  input  logic               zero,
  output logic               instr_valid,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [5:0]         funct,
  output logic [15:0]        imm,
  output logic [IMEM_AW-1:0] pc,
  output logic [IMEM_AW-1:0] pc_plus4
);

  logic [0:0]         state;
  logic [31:0]        ir;
  logic [IMEM_AW-1:0] next_pc;

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

  // Request is gated by reset so an in-flight fetch is dropped immediately.
  assign imem_req  = (state == FETCH) && !reset;
  assign imem_addr = pc;

  fetch_next_pc #(.IMEM_AW(IMEM_AW)) u_next_pc (
    .pc       (pc),
    .opcode   (ir[31:26]),
    .imm      (ir[15:0]),
    .target   (ir[25:0]),
    .branch   (branch),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // FETCH waits for the memory word; HOLD presents it until downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir          <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: if (imem_ready) begin
          ir          <= imem_rdata;
          instr_valid <= 1'b1;
          state       <= HOLD;
        end
        default: if (!stall) begin
          pc          <= next_pc;
          instr_valid <= 1'b0;
          state       <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; main instance at RESET_PC 0, second
// instance at RESET_PC 32'h1000_0000 for the jump case.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_ready, stall, branch, zero;
  logic [31:0] imem_rdata;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, pc, pc_plus4;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;

  logic        j_reset, j_ready, j_stall, j_branch, j_zero;
  logic [31:0] j_rdata;
  logic        j_req, j_valid;
  logic [31:0] j_addr, j_pc, j_pc4;
  logic [5:0]  j_opcode, j_funct;
  logic [4:0]  j_rs, j_rt, j_rd;
  logic [15:0] j_imm;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
    .branch(branch), .zero(zero), .instr_valid(instr_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .funct(funct), .imm(imm), .pc(pc),
    .pc_plus4(pc_plus4)
  );

  fetch_unit #(.RESET_PC(32'h1000_0000)) dut_j (
    .clk(clk), .reset(j_reset), .imem_req(j_req), .imem_addr(j_addr),
    .imem_ready(j_ready), .imem_rdata(j_rdata), .stall(j_stall),
    .branch(j_branch), .zero(j_zero), .instr_valid(j_valid), .opcode(j_opcode),
    .rs(j_rs), .rt(j_rt), .rd(j_rd), .funct(j_funct), .imm(j_imm), .pc(j_pc),
    .pc_plus4(j_pc4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    stall = 1'b0; branch = 1'b0; zero = 1'b0;
    j_reset = 1'b1; j_ready = 1'b0; j_rdata = '0;
    j_stall = 1'b0; j_branch = 1'b0; j_zero = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_pc", pc, 0);

    // Sequential fetch, zero-wait memory
    #2; reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0020;
    #1;
    chk("f0_req", imem_req, 1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_valid", instr_valid, 0);
    tick;
    chk("h0_valid", instr_valid, 1);
    chk("h0_req", imem_req, 0);
    chk("h0_funct", funct, 6'h20);
    chk("h0_opcode", opcode, 0);
    chk("h0_pc4", pc_plus4, 32'h4);
    tick;
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_valid", instr_valid, 0);
    tick;
    chk("h1_valid", instr_valid, 1);
    imem_rdata = 32'h1000_0003;
    tick;
    chk("f2_addr", imem_addr, 32'h8);

    // Taken beq +3 at pc 8
    tick;
    chk("beq_opcode", opcode, 6'b000100);
    chk("beq_imm", imm, 16'h0003);
    branch = 1'b1; zero = 1'b1;
    tick;
    chk("beq_taken_addr", imem_addr, 32'd24);

    // Not taken at 24
    zero = 1'b0;
    tick;
    tick;
    chk("beq_nt_addr", imem_addr, 32'd28);

    // Backward self-loop at 28
    imem_rdata = 32'h1000_FFFF; zero = 1'b1;
    tick;
    tick;
    chk("self_loop_addr", imem_addr, 32'd28);

    // Wait states: ready low for 3 cycles
    imem_ready = 1'b0; branch = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("wait_addr", imem_addr, 32'd28);
      chk("wait_req", imem_req, 1);
      chk("wait_valid", instr_valid, 0);
    end
    imem_ready = 1'b1; imem_rdata = 32'h1000_0002;
    stall = 1'b1; branch = 1'b1; zero = 1'b1;
    tick;
    // Stall 2 cycles in HOLD with branch/zero toggling
    for (int i = 0; i < 2; i++) begin
      chk("stall_pc", pc, 32'd28);
      chk("stall_imm", imm, 16'h0002);
      chk("stall_req", imem_req, 0);
      chk("stall_valid", instr_valid, 1);
      zero = ~zero;
      tick;
    end
    chk("stall_end_pc", pc, 32'd28);
    stall = 1'b0; branch = 1'b1; zero = 1'b0;
    tick;
    chk("post_stall_addr", imem_addr, 32'd32);

    // add at 32, lw at 36, reach FETCH at 40
    branch = 1'b0; imem_rdata = 32'h0000_0020;
    tick; tick;
    chk("f36_addr", imem_addr, 32'd36);
    imem_rdata = 32'h8C00_0000;
    tick; tick;
    imem_ready = 1'b0;
    chk("f40_addr", imem_addr, 32'd40);
    chk("f40_opcode", opcode, 6'b100011);

    // Asynchronous reset mid-fetch
    #2; reset = 1'b1;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", instr_valid, 0);
    chk("arst_opcode", opcode, 0);
    chk("arst_req", imem_req, 0);
    imem_ready = 1'b1; imem_rdata = 32'h0000_0020;
    tick;
    chk("arst_late_ready", instr_valid, 0);
    reset = 1'b0; imem_rdata = 32'h1000_FFFE;
    #1;
    chk("arst_fresh_addr", imem_addr, 32'h0);
    tick;
    chk("arst_fresh_valid", instr_valid, 1);
    branch = 1'b1; zero = 1'b1;
    tick;
    chk("neg_target_addr", imem_addr, 32'hFFFF_FFFC);

    // Wrap from FFFF_FFFC
    branch = 1'b0; zero = 1'b0; imem_rdata = 32'h0000_0020;
    tick;
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick;
    chk("wrap_addr", imem_addr, 32'h0);

    // Jump at 1000_0000
    j_reset = 1'b0; j_ready = 1'b1; j_rdata = 32'h0800_0010;
    #1;
    chk("j_fetch_addr", j_addr, 32'h1000_0000);
    tick;
    chk("j_opcode", j_opcode, 6'b000010);
    tick;
`ifdef FETCH_JUMP_EN
    chk("j_next_addr", j_addr, 32'h1000_0040);
`else
    chk("j_next_addr", j_addr, 32'h1000_0004);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
